// File: rtl/tinycordic_pkg.sv
// Shared definitions for the tinycordic engine: FSM states, mode encoding and
// the arctangent table generator used to build the angle ROM.
package tinycordic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_DONE
  } state_t;

  localparam logic MODE_ROTATE = 1'b0;
  localparam logic MODE_VECTOR = 1'b1;

  // atan(2^-idx) with 2^31 representing 180 degrees, valid for idx 0..23
  function automatic logic [31:0] atan_ref(input int idx);
    case (idx)
      0:       return 32'h2000_0000;
      1:       return 32'h12E4_051E;
      2:       return 32'h09FB_385B;
      3:       return 32'h0511_11D4;
      4:       return 32'h028B_0D43;
      5:       return 32'h0145_D7E1;
      6:       return 32'h00A2_F61E;
      7:       return 32'h0051_7C55;
      8:       return 32'h0028_BE53;
      9:       return 32'h0014_5F2F;
      10:      return 32'h000A_2F98;
      11:      return 32'h0005_17CC;
      12:      return 32'h0002_8BE6;
      13:      return 32'h0001_45F3;
      14:      return 32'h0000_A2FA;
      15:      return 32'h0000_517D;
      16:      return 32'h0000_28BE;
      17:      return 32'h0000_145F;
      18:      return 32'h0000_0A30;
      19:      return 32'h0000_0518;
      20:      return 32'h0000_028C;
      21:      return 32'h0000_0146;
      22:      return 32'h0000_00A3;
      23:      return 32'h0000_0051;
      default: return 32'h0000_0000;
    endcase
  endfunction

  // Rescales the reference so that 2^(width-1) is 180 degrees, rounding to nearest
  function automatic int atan_entry(input int width, input int idx);
    logic [63:0] acc;
    int          shift;
    shift = 32 - width;
    acc   = {32'd0, atan_ref(idx)} + (64'd1 << (shift - 1));
    return int'(acc >> shift);
  endfunction

endpackage

// File: rtl/tinycordic_atan_rom.sv
// Constant table of micro-rotation angles, indexed by the iteration counter.
module tinycordic_atan_rom
  import tinycordic_pkg::*;
#(
  parameter int WIDTH = 12,
  parameter int ITERS = 10
) (
  input  logic [$clog2(ITERS)-1:0] i,
  output logic [WIDTH-1:0]         atan_i
);

  logic [WIDTH-1:0] rom [ITERS];

  for (genvar g = 0; g < ITERS; g++) begin : g_rom
    assign rom[g] = WIDTH'(atan_entry(WIDTH, g));
  end

  assign atan_i = rom[i];

endmodule

// File: rtl/tinycordic_engine.sv
// Iterative CORDIC engine: one micro-rotation per clock, rotation or vectoring
// mode, with valid/ready handshakes on both the operand and result sides.
module tinycordic_engine
  import tinycordic_pkg::*;
#(
  parameter int WIDTH = 12,
  parameter int ITERS = 10
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    mode,
  input  logic signed [WIDTH-1:0] x_in,
  input  logic signed [WIDTH-1:0] y_in,
  input  logic signed [WIDTH-1:0] z_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH+1:0] x_out,
  output logic signed [WIDTH+1:0] y_out,
  output logic signed [WIDTH-1:0] z_out,
  output logic                    busy
);

  localparam int GW = WIDTH + 2;
  localparam int IW = $clog2(ITERS);
  localparam logic signed [WIDTH-1:0] QUARTER     = {2'b01, {(WIDTH-2){1'b0}}};
  localparam logic signed [WIDTH-1:0] NEG_QUARTER = -QUARTER;

  state_t                  state_q, state_d;
  logic                    armed_q;
  logic                    mode_q;
  logic [IW-1:0]           i_q;
  logic signed [GW-1:0]    x_q, y_q;
  logic signed [WIDTH-1:0] z_q;
  logic                    accept;

  logic signed [GW-1:0]    x_ext, y_ext, x_pre, y_pre;
  logic signed [WIDTH-1:0] z_pre;
  logic signed [GW-1:0]    x_sh, y_sh, x_nxt, y_nxt;
  logic signed [WIDTH-1:0] z_nxt;
  logic [WIDTH-1:0]        atan_i;
  logic                    dir_pos;

  tinycordic_atan_rom #(
    .WIDTH (WIDTH),
    .ITERS (ITERS)
  ) u_atan_rom (
    .i      (i_q),
    .atan_i (atan_i)
  );

  assign accept = in_valid && in_ready;

  // Quadrant pre-rotation brings the operand within +/-90 degrees of the x axis
  always_comb begin
    x_ext = GW'(x_in);
    y_ext = GW'(y_in);
    x_pre = x_ext;
    y_pre = y_ext;
    z_pre = z_in;
    if (mode == MODE_ROTATE) begin
      if (z_in > QUARTER) begin
        x_pre = -y_ext;
        y_pre = x_ext;
        z_pre = z_in - QUARTER;
      end else if (z_in < NEG_QUARTER) begin
        x_pre = y_ext;
        y_pre = -x_ext;
        z_pre = z_in + QUARTER;
      end
    end else if (mode == MODE_VECTOR && x_in[WIDTH-1]) begin
      if (!y_in[WIDTH-1]) begin
        x_pre = y_ext;
        y_pre = -x_ext;
        z_pre = z_in + QUARTER;
      end else begin
        x_pre = -y_ext;
        y_pre = x_ext;
        z_pre = z_in - QUARTER;
      end
    end
  end

  always_comb begin
    x_sh    = x_q >>> i_q;
    y_sh    = y_q >>> i_q;
    dir_pos = (mode_q == MODE_ROTATE) ? !z_q[WIDTH-1] : y_q[GW-1];
    if (dir_pos) begin
      x_nxt = x_q - y_sh;
      y_nxt = y_q + x_sh;
      z_nxt = z_q - $signed(atan_i);
    end else begin
      x_nxt = x_q + y_sh;
      y_nxt = y_q - x_sh;
      z_nxt = z_q + $signed(atan_i);
    end
  end

  // armed_q keeps in_ready low until the first edge after reset release
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      armed_q <= 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state_q)
      ST_IDLE: begin
        busy     = 1'b0;
        in_ready = armed_q;
        if (in_valid && armed_q) state_d = ST_CALC;
      end
      ST_CALC: begin
        if (i_q == IW'(ITERS - 1)) state_d = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_q    <= '0;
      y_q    <= '0;
      z_q    <= '0;
      i_q    <= '0;
      mode_q <= MODE_ROTATE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            x_q    <= x_pre;
            y_q    <= y_pre;
            z_q    <= z_pre;
            i_q    <= '0;
            mode_q <= mode;
          end
        end
        ST_CALC: begin
          x_q <= x_nxt;
          y_q <= y_nxt;
          z_q <= z_nxt;
          i_q <= i_q + IW'(1);
        end
        default: ;
      endcase
    end
  end

  assign x_out = out_valid ? x_q : '0;
  assign y_out = out_valid ? y_q : '0;
  assign z_out = out_valid ? z_q : '0;

endmodule

// File: tb/tb_tinycordic_engine.sv
// Directed testbench for tinycordic_engine; expected results are the bit-exact
// 10-step trajectories worked by hand from the integer recurrence.
module tb_tinycordic_engine;
  import tinycordic_pkg::*;

  localparam int WIDTH = 12;
  localparam int ITERS = 10;

  logic                    clk;
  logic                    reset_n;
  logic                    in_valid;
  logic                    in_ready;
  logic                    mode;
  logic signed [WIDTH-1:0] x_in, y_in, z_in;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [WIDTH+1:0] x_out, y_out;
  logic signed [WIDTH-1:0] z_out;
  logic                    busy;

  int checks;
  int failures;

  logic b_mode [3] = '{1'b0, 1'b1, 1'b0};
  int   b_x    [3] = '{607, 300, 607};
  int   b_y    [3] = '{0, 400, 0};
  int   b_z    [3] = '{512, 0, -1024};
  int   b_ex   [3] = '{702, 826, 0};
  int   b_ey   [3] = '{711, -2, -1000};
  int   b_ez   [3] = '{-1, 605, -1};

  tinycordic_engine #(
    .WIDTH (WIDTH),
    .ITERS (ITERS)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .x_in      (x_in),
    .y_in      (y_in),
    .z_in      (z_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .x_out     (x_out),
    .y_out     (y_out),
    .z_out     (z_out),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Offers one operand and returns just after the edge that accepted it
  task automatic applyStimulus(input string tag, input logic m, input int xv, input int yv, input int zv);
    int waited;
    @(negedge clk);
    mode     = m;
    x_in     = WIDTH'(xv);
    y_in     = WIDTH'(yv);
    z_in     = WIDTH'(zv);
    in_valid = 1'b1;
    waited   = 0;
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    checkOutput({tag, "_accept"}, int'(waited < 50), 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checkOutput({tag, "_busy"}, int'(busy), 1);
  endtask

  task automatic waitResult(output int edges);
    edges = 0;
    while (edges < 40) begin
      @(posedge clk);
      #1;
      edges++;
      if (out_valid) break;
    end
  endtask

  task automatic consumeResult(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checkOutput({tag, "_vld_drop"}, int'(out_valid), 0);
    checkOutput({tag, "_x_zero"}, int'(x_out), 0);
    checkOutput({tag, "_idle"}, int'(in_ready), 1);
  endtask

  task automatic runCase(input string tag, input logic m, input int xv, input int yv, input int zv,
                         input int ex, input int ey, input int ez);
    int edges;
    applyStimulus(tag, m, xv, yv, zv);
    waitResult(edges);
    checkOutput({tag, "_latency"}, edges, ITERS);
    checkOutput({tag, "_x"}, int'(x_out), ex);
    checkOutput({tag, "_y"}, int'(y_out), ey);
    checkOutput({tag, "_z"}, int'(z_out), ez);
    checkOutput({tag, "_rdy_low"}, int'(in_ready), 0);
    consumeResult(tag);
  endtask

  task automatic backpressureTest();
    int edges;
    int extra;
    applyStimulus("bp", 1'b1, -300, 400, 0);
    waitResult(edges);
    checkOutput("bp_latency", edges, ITERS);
    in_valid = 1'b1;
    x_in     = WIDTH'(1);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      checkOutput("bp_hold_vld", int'(out_valid), 1);
      checkOutput("bp_hold_x", int'(x_out), 825);
      checkOutput("bp_hold_y", int'(y_out), -2);
      checkOutput("bp_hold_z", int'(z_out), 1445);
      checkOutput("bp_rdy_low", int'(in_ready), 0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    checkOutput("bp_vld_drop", int'(out_valid), 0);
    checkOutput("bp_no_accept", int'(busy), 0);
    extra = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (out_valid || busy) extra++;
    end
    checkOutput("bp_single", extra, 0);
  endtask

  task automatic resetMidCalc();
    int extra;
    applyStimulus("rst", 1'b0, 607, 0, 1536);
    repeat (4) @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    checkOutput("rst_vld", int'(out_valid), 0);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_rdy", int'(in_ready), 0);
    checkOutput("rst_z", int'(z_out), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("rst_rdy_up", int'(in_ready), 1);
    extra = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (out_valid || busy) extra++;
    end
    checkOutput("rst_no_result", extra, 0);
    runCase("post_rst", 1'b0, 607, 0, 512, 702, 711, -1);
  endtask

  task automatic backToBack();
    out_ready = 1'b1;
    fork
      begin
        int waited;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
          mode     = b_mode[k];
          x_in     = WIDTH'(b_x[k]);
          y_in     = WIDTH'(b_y[k]);
          z_in     = WIDTH'(b_z[k]);
          in_valid = 1'b1;
          waited   = 0;
          while (!in_ready && waited < 100) begin
            @(negedge clk);
            waited++;
          end
          checkOutput("b2b_accept", int'(waited < 100), 1);
          @(posedge clk);
          #1;
        end
        in_valid = 1'b0;
      end
      begin
        int got;
        int cyc;
        got = 0;
        cyc = 0;
        while (got < 3 && cyc < 300) begin
          @(negedge clk);
          cyc++;
          if (out_valid) begin
            checkOutput("b2b_rdy_low", int'(in_ready), 0);
            checkOutput("b2b_x", int'(x_out), b_ex[got]);
            checkOutput("b2b_y", int'(y_out), b_ey[got]);
            checkOutput("b2b_z", int'(z_out), b_ez[got]);
            got++;
          end
        end
        checkOutput("b2b_count", got, 3);
      end
    join
    out_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks    = 0;
    failures  = 0;
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    mode      = MODE_ROTATE;
    x_in      = '0;
    y_in      = '0;
    z_in      = '0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_rdy", int'(in_ready), 0);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_vld", int'(out_valid), 0);
    checkOutput("reset_x", int'(x_out), 0);
    checkOutput("reset_y", int'(y_out), 0);
    checkOutput("reset_z", int'(z_out), 0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    checkOutput("release_rdy_low", int'(in_ready), 0);
    @(posedge clk);
    #1;
    checkOutput("release_rdy_up", int'(in_ready), 1);

    runCase("rot45",   MODE_ROTATE, 607,  0,    512,   702,  711,  -1);
    runCase("rot135",  MODE_ROTATE, 607,  0,    1536,  -712, 707,  -1);
    runCase("rotm90",  MODE_ROTATE, 607,  0,    -1024, 0,    -1000, -1);
    runCase("rotm135", MODE_ROTATE, 607,  0,    -1536, -706, -707, -1);
    runCase("vec_q1",  MODE_VECTOR, 300,  400,  0,     826,  -2,   605);
    runCase("vec_q2",  MODE_VECTOR, -300, 400,  0,     825,  -2,   1445);
    runCase("vec_q3",  MODE_VECTOR, -300, -400, 0,     826,  -2,   -1443);

    backpressureTest();
    resetMidCalc();
    backToBack();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
